// File: rtl/rv_pkg.sv
// Shared constants for the operand fetch slice.
// XLEN data width, AW register index width.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/scoreboard.sv
// Per-register busy bits with set-over-clear priority.
// Ports: CLK, CLR, clr_en/clr_idx, set_en/set_idx, busy.
module scoreboard
  import rv_pkg::*;
(
  input  logic            CLK,
  input  logic            CLR,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_next;

  always_comb begin
    w_next = r_busy;
    if (clr_en) w_next[clr_idx] = 1'b0;
    if (set_en) w_next[set_idx] = 1'b1;
    w_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (CLR) r_busy <= '0;
    else     r_busy <= w_next;
  end

  assign busy = r_busy;

endmodule

// File: rtl/operand_fetch.sv
// Reads rs1/rs2 with writeback bypass, stalls on busy regs.
// Ports: in_* handshake, out_* bundle, wb_*, rf_*, busy.
module operand_fetch
  import rv_pkg::*;
(
  input  logic            CLK,
  input  logic            CLR,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_we,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW-1:0]   rf_a1,
  output logic [AW-1:0]   rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic [AW-1:0]   rf_a3,
  output logic            rf_we3,
  output logic [XLEN-1:0] rf_wd3,
  output logic [NREG-1:0] busy
);

  logic            r_valid;
  logic [XLEN-1:0] r_v1;
  logic [XLEN-1:0] r_v2;
  logic [AW-1:0]   r_rd;
  logic            r_rd_we;

  logic [NREG-1:0] w_busy;
  logic            w_eq1, w_eq2, w_eqd;
  logic            w_hit1, w_hit2, w_hitd;
  logic            w_haz;
  logic            w_ready;
  logic            w_issue;
  logic            w_set;
  logic [XLEN-1:0] w_src1, w_src2;

  assign rf_a1  = in_rs1;
  assign rf_a2  = in_rs2;
  assign rf_a3  = wb_rd;
  assign rf_wd3 = wb_data;
  assign rf_we3 = wb_valid && (wb_rd != REG_ZERO);

  assign w_eq1 = wb_valid && (wb_rd == in_rs1);
  assign w_eq2 = wb_valid && (wb_rd == in_rs2);
  assign w_eqd = wb_valid && (wb_rd == in_rd);

  assign w_hit1 = w_eq1 && (in_rs1 != REG_ZERO);
  assign w_hit2 = w_eq2 && (in_rs2 != REG_ZERO);
  assign w_hitd = w_eqd && (in_rd != REG_ZERO);

  always_comb begin
    w_src1 = rf_rd1;
    if (in_rs1 == REG_ZERO) w_src1 = '0;
    else if (w_eq1)         w_src1 = wb_data;
  end

  always_comb begin
    w_src2 = rf_rd2;
    if (in_rs2 == REG_ZERO) w_src2 = '0;
    else if (w_eq2)         w_src2 = wb_data;
  end

  // A writeback landing this cycle releases its register.
  assign w_haz = (w_busy[in_rs1] && !w_hit1)
              || (w_busy[in_rs2] && !w_hit2)
              || (in_rd_we && w_busy[in_rd] && !w_hitd);

  assign w_ready = !w_haz && (!r_valid || out_ready);
  assign w_issue = in_valid && w_ready;
  assign w_set   = w_issue && in_rd_we && (in_rd != REG_ZERO);

  scoreboard u_sb (
    .CLK     (CLK),
    .CLR     (CLR),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .set_en  (w_set),
    .set_idx (in_rd),
    .busy    (w_busy)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_valid <= 1'b0;
      r_v1    <= '0;
      r_v2    <= '0;
      r_rd    <= '0;
      r_rd_we <= 1'b0;
    end else if (w_issue) begin
      r_valid <= 1'b1;
      r_v1    <= w_src1;
      r_v2    <= w_src2;
      r_rd    <= in_rd;
      r_rd_we <= in_rd_we;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign in_ready    = w_ready;
  assign out_valid   = r_valid;
  assign out_rs1_val = r_v1;
  assign out_rs2_val = r_v2;
  assign out_rd      = r_rd;
  assign out_rd_we   = r_rd_we;
  assign busy        = w_busy;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch.
// Directed table plus random run against a reference model.
module tb_operand_fetch;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rf_a1, rf_a2, rf_a3;
  logic [31:0] rf_rd1, rf_rd2, rf_wd3;
  logic        rf_we3;
  logic [31:0] busy;

  always #5 CLK = ~CLK;

  operand_fetch dut (
    .CLK(CLK), .CLR(CLR),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_rd_we(out_rd_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_a1(rf_a1), .rf_a2(rf_a2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_a3(rf_a3), .rf_we3(rf_we3), .rf_wd3(rf_wd3),
    .busy(busy)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 0) return 32'hBAD0BAD0;
    if (i == 1) return 32'h0ABCDEF0;
    if (i == 4) return 32'hFFFFFFFF;
    return 32'h10000000 + i * 32'h01010101;
  endfunction

  logic [31:0] rf_mem [32];
  logic        pl;

  always @(posedge CLK) begin
    if (pl) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
    end else if (rf_we3) begin
      rf_mem[rf_a3] <= rf_wd3;
    end
  end

  assign rf_rd1 = rf_mem[rf_a1];
  assign rf_rd2 = rf_mem[rf_a2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", nm, act, exp);
  endtask

  logic        m_valid;
  logic [31:0] m_v1, m_v2;
  logic [4:0]  m_rd;
  logic        m_we;
  logic [31:0] m_busy;
  logic [31:0] m_rf [32];
  logic        s_rdy;

  typedef struct {
    logic        clr, iv;
    logic [4:0]  rs1, rs2, rd;
    logic        we, ordy, wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        e_rdy, e_ov, e_dchk;
    logic [31:0] e_v1, e_v2, e_busy;
  } vec_t;

  function automatic logic [31:0] src(input logic [4:0] r,
                                      input vec_t v);
    if (r == 0) return 32'h0;
    if (v.wbv && v.wbrd == r) return v.wbd;
    return m_rf[r];
  endfunction

  function automatic logic pend(input logic [4:0] r,
                                input vec_t v);
    return m_busy[r] && !(v.wbv && v.wbrd == r && r != 0);
  endfunction

  task automatic cycle(input vec_t v);
    logic haz, rdy, iss;
    CLR = v.clr; in_valid = v.iv;
    in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_rd = v.rd; in_rd_we = v.we;
    out_ready = v.ordy; wb_valid = v.wbv;
    wb_rd = v.wbrd; wb_data = v.wbd;
    #1;
    haz = pend(v.rs1, v) || pend(v.rs2, v)
       || (v.we && pend(v.rd, v));
    rdy = !haz && (!m_valid || v.ordy);
    iss = v.iv && rdy;
    s_rdy = in_ready;
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    chk("rf_we3", {63'd0, rf_we3},
        {63'd0, v.wbv && v.wbrd != 0});
    if (v.wbv && v.wbrd != 0) m_rf[v.wbrd] = v.wbd;
    if (v.clr) begin
      m_valid = 0; m_v1 = 0; m_v2 = 0;
      m_rd = 0; m_we = 0; m_busy = 0;
    end else begin
      if (iss) begin
        m_valid = 1; m_v1 = src(v.rs1, v);
        m_v2 = src(v.rs2, v);
        m_rd = v.rd; m_we = v.we;
      end else if (v.ordy) m_valid = 0;
      if (v.wbv) m_busy[v.wbrd] = 1'b0;
      if (iss && v.we && v.rd != 0) m_busy[v.rd] = 1'b1;
    end
    @(posedge CLK);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("out_rs1", {32'd0, out_rs1_val}, {32'd0, m_v1});
    chk("out_rs2", {32'd0, out_rs2_val}, {32'd0, m_v2});
    chk("out_rd", {59'd0, out_rd}, {59'd0, m_rd});
    chk("out_rd_we", {63'd0, out_rd_we}, {63'd0, m_we});
    chk("busy", {32'd0, busy}, {32'd0, m_busy});
    @(negedge CLK);
  endtask

  function automatic vec_t mk(
      input logic c, iv, input logic [4:0] r1, r2, rd,
      input logic we, o, wv, input logic [4:0] wr,
      input logic [31:0] wd, input logic er, eo, ed,
      input logic [31:0] e1, e2, eb);
    vec_t v;
    v.clr = c; v.iv = iv; v.rs1 = r1; v.rs2 = r2;
    v.rd = rd; v.we = we; v.ordy = o; v.wbv = wv;
    v.wbrd = wr; v.wbd = wd; v.e_rdy = er; v.e_ov = eo;
    v.e_dchk = ed; v.e_v1 = e1; v.e_v2 = e2; v.e_busy = eb;
    return v;
  endfunction

  localparam logic [31:0] B5 = 32'h20;
  localparam logic [31:0] B6 = 32'h40;
  localparam logic [31:0] B67 = 32'hC0;

  vec_t tbl [15];
  vec_t rv;

  initial begin
    tbl[0]  = mk(1,1,1,4,0,0,1,0,0,0, 1,0,0, 0,0,0);
    tbl[1]  = mk(0,1,1,4,0,0,1,0,0,0, 1,1,1,
                 32'h0ABCDEF0, 32'hFFFFFFFF, 0);
    tbl[2]  = mk(0,1,0,0,5,1,1,1,0,32'h12345678,
                 1,1,1, 0,0,B5);
    tbl[3]  = mk(0,1,5,0,6,1,1,0,0,0, 0,0,0, 0,0,B5);
    tbl[4]  = tbl[3];
    tbl[5]  = tbl[3];
    tbl[6]  = mk(0,1,5,0,6,1,1,1,5,32'hDEADBEEF,
                 1,1,1, 32'hDEADBEEF,0,B6);
    tbl[7]  = mk(0,1,1,4,0,0,0,0,0,0, 0,1,1,
                 32'hDEADBEEF,0,B6);
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = tbl[7];
    tbl[11] = mk(0,1,1,4,0,0,1,0,0,0, 1,1,1,
                 32'h0ABCDEF0, 32'hFFFFFFFF, B6);
    tbl[12] = mk(0,1,0,0,7,1,1,0,0,0, 1,1,1, 0,0,B67);
    tbl[13] = mk(0,1,0,0,7,1,1,1,7,32'hCAFEF00D,
                 1,1,1, 0,0,B67);
    tbl[14] = mk(1,0,0,0,0,0,0,1,2,32'h55AA55AA,
                 0,0,0, 0,0,0);

    CLR = 1; in_valid = 1; in_rs1 = 1; in_rs2 = 4;
    in_rd = 0; in_rd_we = 0; out_ready = 1;
    wb_valid = 0; wb_rd = 0; wb_data = 0; pl = 1;
    for (int i = 0; i < 32; i++) m_rf[i] = init_val(i);
    m_valid = 0; m_v1 = 0; m_v2 = 0; m_rd = 0;
    m_we = 0; m_busy = 0; s_rdy = 0;
    @(posedge CLK);
    #1 pl = 0;
    @(negedge CLK);

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i]);
      chk($sformatf("t%0d rdy", i),
          {63'd0, s_rdy}, {63'd0, tbl[i].e_rdy});
      chk($sformatf("t%0d ov", i),
          {63'd0, out_valid}, {63'd0, tbl[i].e_ov});
      chk($sformatf("t%0d busy", i),
          {32'd0, busy}, {32'd0, tbl[i].e_busy});
      if (tbl[i].e_dchk) begin
        chk($sformatf("t%0d v1", i),
            {32'd0, out_rs1_val}, {32'd0, tbl[i].e_v1});
        chk($sformatf("t%0d v2", i),
            {32'd0, out_rs2_val}, {32'd0, tbl[i].e_v2});
      end
      if (i == 13)
        chk("rf x7", {32'd0, rf_mem[7]}, 64'hCAFEF00D);
    end
    chk("rf x2", {32'd0, rf_mem[2]}, 64'h55AA55AA);

    for (int n = 0; n < 400; n++) begin
      rv = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,0);
      rv.clr  = ($urandom_range(0, 63) == 0);
      rv.iv   = ($urandom_range(0, 9) < 7);
      rv.rs1  = 5'($urandom_range(0, 7));
      rv.rs2  = 5'($urandom_range(0, 7));
      rv.rd   = 5'($urandom_range(0, 7));
      rv.we   = ($urandom_range(0, 3) != 0);
      rv.ordy = ($urandom_range(0, 3) != 0);
      rv.wbv  = ($urandom_range(0, 9) < 4);
      rv.wbrd = 5'($urandom_range(0, 7));
      rv.wbd  = $urandom;
      cycle(rv);
      chk("busy0", {63'd0, busy[0]}, 64'd0);
    end

    for (int i = 1; i < 32; i++)
      chk($sformatf("rf x%0d", i),
          {32'd0, rf_mem[i]}, {32'd0, m_rf[i]});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule
